cordic_job_sequencer: RTL and testbench

//   Sequences one CORDIC evaluation over a narrow pin-level bus: gathers an angle in CHUNK_W-bit

---
 rtl/cordic_job_sequencer.sv | 164 ++++++++++++++++
 tb/tb_cordic_job_sequencer.sv | 561 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_job_sequencer.sv
// rtl/cordic_job_sequencer.sv - chunked angle in, one CORDIC start/wait, chunked cos/sin out
// Optional quadrant folding: define CORDIC_SEQ_QUADRANT_EN.
module cordic_job_sequencer #(
   parameter int ANGLE_W     = 16,
   parameter int RES_W       = 16,
   parameter int CHUNK_W     = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CHUNK_W-1:0] in_data,
   input  logic               in_valid,
   input  logic               in_mode,
   output logic [CHUNK_W-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic               err,
   output logic [ANGLE_W-1:0] core_angle,
   output logic               core_mode,
   output logic               core_start,
   input  logic               core_done,
   input  logic [RES_W-1:0]   core_cos,
   input  logic [RES_W-1:0]   core_sin
);

   localparam int NIN  = ANGLE_W / CHUNK_W;
   localparam int NOUT = 2 * RES_W / CHUNK_W;
   localparam int CIW  = (NIN > 1) ? $clog2(NIN) : 1;
   localparam int COW  = $clog2(NOUT);
   localparam int TW   = $clog2(TIMEOUT_CYC);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_EMIT} state_t;

   state_t             state, state_nxt;
   logic [ANGLE_W-1:0] angle_sh, angle_ins, angle_core;
   logic               mode_reg, mode_first;
   logic [CIW-1:0]     chunk_cnt, chunk_idx;
   logic [TW-1:0]      tmo_cnt;
   logic [COW-1:0]     out_cnt;
   logic [RES_W-1:0]   cos_reg, sin_reg, cap_cos, cap_sin;
   logic [2*RES_W-1:0] res_word;
   logic               accept, last_in, last_out, tmo_last;

   assign accept    = in_valid && (state == S_IDLE || state == S_LOAD);
   assign chunk_idx = (state == S_IDLE) ? '0 : chunk_cnt;
   assign last_in   = (chunk_idx == CIW'(NIN - 1));
   assign last_out  = (out_cnt == COW'(NOUT - 1));
   assign tmo_last  = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
   assign mode_first = (state == S_IDLE) ? in_mode : mode_reg;
   assign res_word  = {sin_reg, cos_reg};

   always_comb begin
      angle_ins = angle_sh;
      angle_ins[chunk_idx*CHUNK_W +: CHUNK_W] = in_data;
   end

`ifdef CORDIC_SEQ_QUADRANT_EN
   // Two's-complement negate with the most-negative value clamped to most-positive.
   function automatic logic [RES_W-1:0] sat_neg(input logic [RES_W-1:0] v);
      if (v == {1'b1, {(RES_W-1){1'b0}}})
         return {1'b0, {(RES_W-1){1'b1}}};
      return -v;
   endfunction

   assign angle_core = {2'b00, angle_ins[ANGLE_W-3:0]};

   // angle_sh still holds the full job angle while waiting, so its quadrant bits drive the fold-back.
   always_comb begin
      cap_cos = core_cos;
      cap_sin = core_sin;
      case (angle_sh[ANGLE_W-1 -: 2])
         2'd1: begin cap_cos = sat_neg(core_sin); cap_sin = core_cos;          end
         2'd2: begin cap_cos = sat_neg(core_cos); cap_sin = sat_neg(core_sin); end
         2'd3: begin cap_cos = core_sin;          cap_sin = sat_neg(core_cos); end
         default: ;
      endcase
   end
`else
   assign angle_core = angle_ins;

   always_comb begin
      cap_cos = core_cos;
      cap_sin = core_sin;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_LOAD: if (in_valid) state_nxt = last_in ? S_START : S_LOAD;
         S_START:        state_nxt = S_WAIT;
         S_WAIT: begin
            if (core_done)
               state_nxt = S_EMIT;
            else if (tmo_last)
               state_nxt = S_IDLE;
         end
         S_EMIT:         if (out_ready && last_out) state_nxt = S_IDLE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      core_start = (state == S_START);
      busy       = (state == S_START) || (state == S_WAIT) || (state == S_EMIT);
      out_valid  = (state == S_EMIT);
      out_data   = '0;
      if (state == S_EMIT)
         out_data = res_word[out_cnt*CHUNK_W +: CHUNK_W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         angle_sh   <= '0;
         mode_reg   <= 1'b0;
         chunk_cnt  <= '0;
         tmo_cnt    <= '0;
         out_cnt    <= '0;
         cos_reg    <= '0;
         sin_reg    <= '0;
         err        <= 1'b0;
         core_angle <= '0;
         core_mode  <= 1'b0;
      end else begin
         if (accept) begin
            angle_sh  <= angle_ins;
            chunk_cnt <= last_in ? '0 : chunk_idx + CIW'(1);
            if (state == S_IDLE) begin
               mode_reg <= in_mode;
               err      <= 1'b0;
            end
            // Core-side angle only moves once a complete job angle is known.
            if (last_in) begin
               core_angle <= angle_core;
               core_mode  <= mode_first;
            end
         end
         if (state == S_START) begin
            tmo_cnt <= '0;
            out_cnt <= '0;
         end
         if (state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (core_done) begin
               cos_reg <= cap_cos;
               sin_reg <= cap_sin;
            end else if (tmo_last) begin
               err <= 1'b1;
            end
         end
         if (state == S_EMIT && out_ready)
            out_cnt <= last_out ? '0 : out_cnt + COW'(1);
      end
   end

endmodule

// File: tb/tb_cordic_job_sequencer.sv
// tb/tb_cordic_job_sequencer.sv - scoreboard bench for cordic_job_sequencer with a delayed-done core stub
module tb_cordic_job_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_mode;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        err;
   logic [15:0] core_angle;
   logic        core_mode;
   logic        core_start;
   logic        core_done = 1'b0;
   logic [15:0] core_cos;
   logic [15:0] core_sin;

   int          total = 0;
   int          bad = 0;

   int          stub_delay = 5;
   logic [15:0] stub_cos = '0;
   logic [15:0] stub_sin = '0;
   int          stub_rem = 0;
   bit          stub_armed = 1'b0;
   int          spur_req = 0;
   int          spur_ack = 0;
   int          start_cnt = 0;
   int          ov_cnt = 0;
   logic [7:0]  got_mem [0:255];
   int          got_wr = 0;
   int          got_rd = 0;
   logic [7:0]  exp_q [$];

   cordic_job_sequencer #(
      .ANGLE_W(16), .RES_W(16), .CHUNK_W(8), .TIMEOUT_CYC(64)
   ) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_mode(in_mode),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .err(err),
      .core_angle(core_angle), .core_mode(core_mode), .core_start(core_start),
      .core_done(core_done), .core_cos(core_cos), .core_sin(core_sin)
   );

   always #5 clk = ~clk;

   assign core_cos = stub_cos;
   assign core_sin = stub_sin;

   // Core stub and output monitor: done pulses stub_delay cycles after the start cycle.
   always @(negedge clk) begin
      core_done = 1'b0;
      if (stub_armed) begin
         stub_rem = stub_rem - 1;
         if (stub_rem == 0) begin
            core_done  = 1'b1;
            stub_armed = 1'b0;
         end
      end
      if (core_start) begin
         start_cnt = start_cnt + 1;
         if (stub_delay > 0) begin
            stub_armed = 1'b1;
            stub_rem   = stub_delay;
         end
      end
      if (spur_req != spur_ack) begin
         core_done = 1'b1;
         spur_ack  = spur_ack + 1;
      end
      if (out_valid)
         ov_cnt = ov_cnt + 1;
      if (out_valid && out_ready) begin
         got_mem[got_wr[7:0]] = out_data;
         got_wr = got_wr + 1;
      end
   end

   task automatic tick_s();
      @(negedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [15:0] c, input logic [15:0] s);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
      exp_q.push_back(s[7:0]);
      exp_q.push_back(s[15:8]);
   endtask

   task automatic send_angle(input logic [15:0] a, input logic m);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = a[7:0]; in_mode = m;
      @(posedge clk); #1;
      in_data = a[15:8]; in_mode = ~m;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
   endtask

   task automatic wait_got(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (got_wr - got_rd >= n) begin
            ok = 1'b1;
            break;
         end
         tick_s();
      end
   endtask

   task automatic test_reset();
      #3;
      total++;
      if ({busy, out_valid, core_start, err, core_mode, core_angle, out_data} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got busy=%b ov=%b st=%b err=%b cm=%b ca=%h od=%h want all 0",
                  busy, out_valid, core_start, err, core_mode, core_angle, out_data);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      tick_s();
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release_idle got busy=%b ov=%b want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_basic();
      int n;
      int s0;
      bit ok;
      logic [7:0] e;
      stub_delay = 5; stub_cos = 16'h7FFF; stub_sin = 16'h0000; out_ready = 1'b1;
      push_exp(16'h7FFF, 16'h0000);
      s0 = start_cnt;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 8'h34; in_mode = 1'b1;
      @(posedge clk); #1;
      in_data = 8'h12; in_mode = 1'b0;
      tick_s();
      total++;
      if (core_start !== 1'b0) begin
         bad++;
         $display("FAIL basic_early_start got %b want 0", core_start);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      tick_s();
      total++;
      if (core_start !== 1'b1 || core_angle !== 16'h1234 || core_mode !== 1'b1) begin
         bad++;
         $display("FAIL basic_start got st=%b ca=%h cm=%b want 1 1234 1", core_start, core_angle, core_mode);
      end
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick_s();
         n++;
         if (n == 1) begin
            total++;
            if (core_start !== 1'b0) begin
               bad++;
               $display("FAIL basic_start_width got %b want 0", core_start);
            end
         end
         if (out_valid) break;
      end
      total++;
      if (n != 6) begin
         bad++;
         $display("FAIL basic_out_latency got %0d want 6", n);
      end
      wait_got(4, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL basic_drain got %0d chunks want 4", got_wr - got_rd);
         exp_q.delete(); got_rd = got_wr;
      end else begin
         for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            total++;
            if (got_mem[got_rd[7:0]] !== e) begin
               bad++;
               $display("FAIL basic_chunk%0d got %h want %h", i, got_mem[got_rd[7:0]], e);
            end
            got_rd++;
         end
      end
      tick_s();
      total++;
      if (busy !== 1'b0 || start_cnt - s0 != 1) begin
         bad++;
         $display("FAIL basic_end got busy=%b starts=%0d want 0 1", busy, start_cnt - s0);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] expb [0:3];
      bit ok;
      logic [7:0] e;
      expb[0] = 8'h5A; expb[1] = 8'hA5; expb[2] = 8'h01; expb[3] = 8'h80;
      stub_delay = 2; stub_cos = 16'hA55A; stub_sin = 16'h8001; out_ready = 1'b0;
      push_exp(16'hA55A, 16'h8001);
      send_angle(16'h2A5C, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick_s();
         if (out_valid) break;
      end
      for (int k = 0; k < 4; k++) begin
         for (int w = 0; w < 3; w++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== expb[k] || busy !== 1'b1) begin
               bad++;
               $display("FAIL bp_hold%0d got ov=%b od=%h busy=%b want 1 %h 1", k, out_valid, out_data, busy, expb[k]);
            end
            tick_s();
         end
         @(posedge clk); #1;
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         if (k == 3) begin
            stub_delay = 1; stub_cos = 16'h8000; stub_sin = 16'h7FFF;
            push_exp(16'h8000, 16'h7FFF);
            in_valid = 1'b1; in_data = 8'h0F; in_mode = 1'b1;
         end
         tick_s();
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_idle_after_last got busy=%b want 0", busy);
      end
      @(posedge clk); #1;
      in_data = 8'h0F; in_mode = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      tick_s();
      total++;
      if (core_start !== 1'b1 || core_angle !== 16'h0F0F || core_mode !== 1'b1) begin
         bad++;
         $display("FAIL bp_b2b_start got st=%b ca=%h cm=%b want 1 0f0f 1", core_start, core_angle, core_mode);
      end
      wait_got(8, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL bp_drain got %0d chunks want 8", got_wr - got_rd);
         exp_q.delete(); got_rd = got_wr;
      end else begin
         for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            total++;
            if (got_mem[got_rd[7:0]] !== e) begin
               bad++;
               $display("FAIL bp_chunk%0d got %h want %h", i, got_mem[got_rd[7:0]], e);
            end
            got_rd++;
         end
      end
      tick_s();
   endtask

   task automatic test_timeout();
      int n;
      int nb;
      int o0;
      bit ok;
      logic [7:0] e;
      stub_delay = -1;
      o0 = ov_cnt;
      send_angle(16'h3333, 1'b1);
      tick_s();
      n = 0; nb = 0;
      for (int i = 0; i < 100; i++) begin
         tick_s();
         if (err) break;
         n++;
         if (busy !== 1'b1) nb++;
      end
      total++;
      if (n != 64 || nb != 0) begin
         bad++;
         $display("FAIL timeout_wait_cycles got %0d (busy drops %0d) want 64 (0)", n, nb);
      end
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || ov_cnt != o0) begin
         bad++;
         $display("FAIL timeout_abandon got err=%b busy=%b ov_cycles=%0d want 1 0 0", err, busy, ov_cnt - o0);
      end
      stub_delay = 4; stub_cos = 16'h0123; stub_sin = 16'hFEDC;
      push_exp(16'h0123, 16'hFEDC);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 8'h33; in_mode = 1'b0;
      tick_s();
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL timeout_err_sticky got %b want 1", err);
      end
      @(posedge clk); #1;
      in_data = 8'h33;
      tick_s();
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL timeout_err_clear got %b want 0", err);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_got(4, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL timeout_recover_drain got %0d chunks want 4", got_wr - got_rd);
         exp_q.delete(); got_rd = got_wr;
      end else begin
         for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            total++;
            if (got_mem[got_rd[7:0]] !== e) begin
               bad++;
               $display("FAIL timeout_recover_chunk%0d got %h want %h", i, got_mem[got_rd[7:0]], e);
            end
            got_rd++;
         end
      end
      tick_s();
   endtask

   task automatic test_timeout_edge();
      int n;
      int o0;
      bit ok;
      logic [7:0] e;
      stub_delay = 64; stub_cos = 16'h1111; stub_sin = 16'h2222; out_ready = 1'b1;
      push_exp(16'h1111, 16'h2222);
      send_angle(16'h0A0B, 1'b0);
      tick_s();
      n = 0;
      for (int i = 0; i < 100; i++) begin
         tick_s();
         n++;
         if (out_valid) break;
      end
      total++;
      if (n != 65 || err !== 1'b0) begin
         bad++;
         $display("FAIL edge_done_wins got latency=%0d err=%b want 65 0", n, err);
      end
      wait_got(4, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL edge_drain got %0d chunks want 4", got_wr - got_rd);
         exp_q.delete(); got_rd = got_wr;
      end else begin
         for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            total++;
            if (got_mem[got_rd[7:0]] !== e) begin
               bad++;
               $display("FAIL edge_chunk%0d got %h want %h", i, got_mem[got_rd[7:0]], e);
            end
            got_rd++;
         end
      end
      tick_s();
      stub_delay = 65;
      o0 = ov_cnt;
      send_angle(16'h0B0C, 1'b0);
      repeat (72) tick_s();
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || ov_cnt != o0) begin
         bad++;
         $display("FAIL edge_late_done got err=%b busy=%b ov_cycles=%0d want 1 0 0", err, busy, ov_cnt - o0);
      end
   endtask

   task automatic test_ignore();
      int s0;
      int o0;
      bit ok;
      logic [7:0] e;
      stub_delay = 8; stub_cos = 16'h4321; stub_sin = 16'h8765; out_ready = 1'b0;
      push_exp(16'h4321, 16'h8765);
      send_angle(16'h1357, 1'b1);
      tick_s();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; in_data = 8'($urandom); in_mode = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick_s();
         if (out_valid) break;
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; in_data = 8'($urandom);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      tick_s();
      total++;
      if (core_angle !== 16'h1357 || core_mode !== 1'b1 || err !== 1'b0) begin
         bad++;
         $display("FAIL ignore_core_hold got ca=%h cm=%b err=%b want 1357 1 0", core_angle, core_mode, err);
      end
      wait_got(4, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL ignore_drain got %0d chunks want 4", got_wr - got_rd);
         exp_q.delete(); got_rd = got_wr;
      end else begin
         for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            total++;
            if (got_mem[got_rd[7:0]] !== e) begin
               bad++;
               $display("FAIL ignore_chunk%0d got %h want %h", i, got_mem[got_rd[7:0]], e);
            end
            got_rd++;
         end
      end
      tick_s();
      s0 = start_cnt; o0 = ov_cnt;
      spur_req++;
      repeat (4) tick_s();
      total++;
      if (busy !== 1'b0 || ov_cnt != o0 || start_cnt != s0) begin
         bad++;
         $display("FAIL ignore_idle_done got busy=%b ov_cycles=%0d starts=%0d want 0 0 0", busy, ov_cnt - o0, start_cnt - s0);
      end
   endtask

   task automatic test_reset_mid();
      int o0;
      bit ok;
      logic [7:0] e;
      stub_delay = 10; stub_cos = 16'h5555; stub_sin = 16'h6666; out_ready = 1'b1;
      send_angle(16'h2468, 1'b1);
      tick_s();
      repeat (3) tick_s();
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({busy, out_valid, core_start, err, core_mode, core_angle, out_data} !== '0) begin
         bad++;
         $display("FAIL rstmid_outputs got busy=%b ov=%b st=%b err=%b cm=%b ca=%h od=%h want all 0",
                  busy, out_valid, core_start, err, core_mode, core_angle, out_data);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      o0 = ov_cnt;
      repeat (12) tick_s();
      total++;
      if (busy !== 1'b0 || ov_cnt != o0 || core_angle !== 16'h0000) begin
         bad++;
         $display("FAIL rstmid_done_ignored got busy=%b ov_cycles=%0d ca=%h want 0 0 0000", busy, ov_cnt - o0, core_angle);
      end
      stub_delay = 3; stub_cos = 16'hCAFE; stub_sin = 16'h0BEE;
      push_exp(16'hCAFE, 16'h0BEE);
      send_angle(16'h0C0D, 1'b0);
      wait_got(4, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL rstmid_recover_drain got %0d chunks want 4", got_wr - got_rd);
         exp_q.delete(); got_rd = got_wr;
      end else begin
         for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            total++;
            if (got_mem[got_rd[7:0]] !== e) begin
               bad++;
               $display("FAIL rstmid_recover_chunk%0d got %h want %h", i, got_mem[got_rd[7:0]], e);
            end
            got_rd++;
         end
      end
      tick_s();
   endtask

`ifdef CORDIC_SEQ_QUADRANT_EN
   task automatic test_quadrant();
      logic [15:0] ang [0:2];
      logic [15:0] qca [0:2];
      logic [15:0] sc  [0:2];
      logic [15:0] ss  [0:2];
      logic [15:0] ec  [0:2];
      logic [15:0] es  [0:2];
      bit ok;
      logic [7:0] e;
      ang[0] = 16'h4100; qca[0] = 16'h0100; sc[0] = 16'h1000; ss[0] = 16'h0200; ec[0] = 16'hFE00; es[0] = 16'h1000;
      ang[1] = 16'h8000; qca[1] = 16'h0000; sc[1] = 16'h8000; ss[1] = 16'h1234; ec[1] = 16'h7FFF; es[1] = 16'hEDCC;
      ang[2] = 16'hC000; qca[2] = 16'h0000; sc[2] = 16'h0100; ss[2] = 16'h8000; ec[2] = 16'h8000; es[2] = 16'hFF00;
      out_ready = 1'b1; stub_delay = 2;
      for (int j = 0; j < 3; j++) begin
         stub_cos = sc[j]; stub_sin = ss[j];
         push_exp(ec[j], es[j]);
         send_angle(ang[j], 1'b0);
         tick_s();
         total++;
         if (core_angle !== qca[j]) begin
            bad++;
            $display("FAIL quad%0d_core_angle got %h want %h", j, core_angle, qca[j]);
         end
         repeat (10) tick_s();
      end
      wait_got(12, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL quad_drain got %0d chunks want 12", got_wr - got_rd);
         exp_q.delete(); got_rd = got_wr;
      end else begin
         for (int i = 0; i < 12; i++) begin
            e = exp_q.pop_front();
            total++;
            if (got_mem[got_rd[7:0]] !== e) begin
               bad++;
               $display("FAIL quad_chunk%0d got %h want %h", i, got_mem[got_rd[7:0]], e);
            end
            got_rd++;
         end
      end
   endtask
`endif

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_timeout();
      test_timeout_edge();
      test_ignore();
      test_reset_mid();
`ifdef CORDIC_SEQ_QUADRANT_EN
      test_quadrant();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
